// File: rtl/dadda_mul_pkg.sv
// Shared types, widths and the round-robin pick function for the Dadda multiplier scheduler.
package dadda_mul_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned PROD_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RSP  = 2'd2
  } state_e;

  // One-hot pick of the first set bit of valid[n-1:0], searching upward from ptr with wrap.
  // Requires ptr < n and n in 1..8.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [7:0] grant;
    logic       found;
    logic [3:0] idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = 4'(ptr) + 4'(i);
      if (idx >= n) idx = idx - n;
      if ((4'(i) < n) && !found && valid[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req_valid starting at rr_ptr, gated by enable.
module rr_arbiter
  import dadda_mul_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  logic [7:0] valid_pad;
  logic [7:0] pick;

  // Pad the request vector to the fixed width of rr_pick and trim the result back.
  always_comb begin
    valid_pad             = '0;
    valid_pad[NREQ-1:0]   = req_valid;
    pick                  = rr_pick(valid_pad, 3'(rr_ptr), 4'(NREQ));
    grant                 = enable ? pick[NREQ-1:0] : '0;
  end

endmodule

// File: rtl/six_bit_dadda_mutliplier.sv
// 6x6 unsigned Dadda multiplier: partial-product matrix reduced to heights 4, 3, 2 with
// half/full adders, then a final carry-propagate add of the two remaining rows.
module six_bit_dadda_mutliplier
  import dadda_mul_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] prod_o
);

  // Column compression; heights are data-independent so the loops unroll to a fixed tree.
  always_comb begin : reduce
    logic              m   [PROD_W][8];
    logic              n   [PROD_W][8];
    logic [3:0]        h   [PROD_W];
    logic [3:0]        nh  [PROD_W];
    logic [3:0]        p;
    logic [3:0]        d;
    logic [PROD_W-1:0] row0;
    logic [PROD_W-1:0] row1;

    for (int c = 0; c < PROD_W; c++) begin
      h[c]  = '0;
      nh[c] = '0;
      for (int k = 0; k < 8; k++) begin
        m[c][k] = 1'b0;
        n[c][k] = 1'b0;
      end
    end
    p = '0;
    d = '0;

    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        m[i+j][h[i+j][2:0]] = a_i[i] & b_i[j];
        h[i+j]              = h[i+j] + 4'd1;
      end
    end

    for (int s = 0; s < 3; s++) begin
      d = 4'd4 - 4'(s);
      for (int c = 0; c < PROD_W; c++) begin
        nh[c] = '0;
        for (int k = 0; k < 8; k++) n[c][k] = 1'b0;
      end
      for (int c = 0; c < PROD_W; c++) begin
        p = '0;
        // Carries already placed in n[c] count toward the column height.
        for (int r = 0; r < 3; r++) begin
          if ((h[c] - p) + nh[c] > d) begin
            if ((h[c] - p) + nh[c] - d == 4'd1) begin
              n[c][nh[c][2:0]] = m[c][p[2:0]] ^ m[c][p[2:0]+3'd1];
              nh[c]            = nh[c] + 4'd1;
              if (c < PROD_W - 1) begin
                n[c+1][nh[c+1][2:0]] = m[c][p[2:0]] & m[c][p[2:0]+3'd1];
                nh[c+1]              = nh[c+1] + 4'd1;
              end
              p = p + 4'd2;
            end else begin
              n[c][nh[c][2:0]] = m[c][p[2:0]] ^ m[c][p[2:0]+3'd1] ^ m[c][p[2:0]+3'd2];
              nh[c]            = nh[c] + 4'd1;
              if (c < PROD_W - 1) begin
                n[c+1][nh[c+1][2:0]] = (m[c][p[2:0]] & m[c][p[2:0]+3'd1]) |
                                       (m[c][p[2:0]] & m[c][p[2:0]+3'd2]) |
                                       (m[c][p[2:0]+3'd1] & m[c][p[2:0]+3'd2]);
                nh[c+1]              = nh[c+1] + 4'd1;
              end
              p = p + 4'd3;
            end
          end
        end
        for (int k = 0; k < 8; k++) begin
          if ((4'(k) >= p) && (4'(k) < h[c])) begin
            n[c][nh[c][2:0]] = m[c][k];
            nh[c]            = nh[c] + 4'd1;
          end
        end
      end
      for (int c = 0; c < PROD_W; c++) begin
        h[c] = nh[c];
        for (int k = 0; k < 8; k++) m[c][k] = n[c][k];
      end
    end

    for (int c = 0; c < PROD_W; c++) begin
      row0[c] = m[c][0];
      row1[c] = m[c][1];
    end
    prod_o = row0 + row1;
  end

endmodule

// File: rtl/dadda_mul_scheduler.sv
// Shares one 6x6 Dadda multiplier among NREQ requesters with round-robin arbitration and a
// single registered response channel. Define DADDA_MUL_SCHED_CHECK_EN to add the chk_err
// self-check output comparing the Dadda product with a behavioural multiply.
module dadda_mul_scheduler
  import dadda_mul_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PROD_W-1:0]      rsp_prod,
  input  logic                   rsp_ready,
  output logic                   busy
`ifdef DADDA_MUL_SCHED_CHECK_EN
  ,
  output logic                   chk_err
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0] rsp_prod_q, rsp_prod_d;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   win_id;
  logic [PROD_W-1:0] mul_prod;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (state_q == IDLE),
    .grant     (grant)
  );

  six_bit_dadda_mutliplier u_mul (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .prod_o (mul_prod)
  );

  // Encode the one-hot grant into the winner's index.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win_id = ID_W'(i);
    end
  end

  // FSM next state, operand capture and response update.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_id_d    = op_id_q;
    rsp_id_d   = rsp_id_q;
    rsp_prod_d = rsp_prod_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          op_a_d   = req_a[OP_W*win_id +: OP_W];
          op_b_d   = req_b[OP_W*win_id +: OP_W];
          op_id_d  = win_id;
          rr_ptr_d = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
          state_d  = MUL;
        end
      end
      MUL: begin
        rsp_prod_d = mul_prod;
        rsp_id_d   = op_id_q;
        state_d    = RSP;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_id_q    <= '0;
      rsp_id_q   <= '0;
      rsp_prod_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_id_q    <= op_id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_prod_q <= rsp_prod_d;
    end
  end

  // Outputs decoded from registered state only (req_ready is the combinational grant).
  always_comb begin
    req_ready = grant;
    rsp_valid = (state_q == RSP);
    busy      = (state_q != IDLE);
    rsp_id    = rsp_id_q;
    rsp_prod  = rsp_prod_q;
  end

`ifdef DADDA_MUL_SCHED_CHECK_EN
  logic chk_err_q, chk_err_d;

  // Sticky flag when the tree disagrees with a plain multiply.
  always_comb begin
    chk_err_d = chk_err_q;
    if ((state_q == MUL) && (mul_prod != ({6'b0, op_a_q} * {6'b0, op_b_q}))) chk_err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_dadda_mul_scheduler.sv
// Directed bench for dadda_mul_scheduler (NREQ=4). Inputs change on the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
module tb_dadda_mul_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*6-1:0] req_a;
  logic [NREQ*6-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [11:0]       rsp_prod;
  logic              rsp_ready;
  logic              busy;
`ifdef DADDA_MUL_SCHED_CHECK_EN
  logic              chk_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dadda_mul_scheduler #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef DADDA_MUL_SCHED_CHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  task automatic set_op(input int i, input logic [5:0] a, input logic [5:0] b);
    req_a[6*i +: 6] = a;
    req_b[6*i +: 6] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset asserted while a response is pending clears everything immediately.
  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_prod, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got rdy=%b v=%b id=%0d p=%0d busy=%b want all 0",
               req_ready, rsp_valid, rsp_id, rsp_prod, busy);
    end
    set_op(2, 6'd7, 6'd3);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_prod !== 12'd21) begin
      n_fail++;
      $display("FAIL reset_pre_rsp: got v=%b p=%0d want v=1 p=21", rsp_valid, rsp_prod);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_prod, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_rsp: got rdy=%b v=%b id=%0d p=%0d busy=%b want all 0",
               req_ready, rsp_valid, rsp_id, rsp_prod, busy);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_rr_ptr: got req_ready=%b want 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  // Single request with maximal operands.
  task automatic test_single();
    do_reset();
    set_op(0, 6'd63, 6'd63);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_mul: got rdy=%b v=%b busy=%b want 0000 0 1", req_ready, rsp_valid,
               busy);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_prod !== 12'd3969 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b p=%0d id=%0d want 1 3969 0", rsp_valid, rsp_prod,
               rsp_id);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  // All requesters held valid: grants rotate 0,1,2,3,0 every 3 cycles.
  task automatic test_back_to_back();
    logic [11:0] exp_prod [4] = '{12'd200, 12'd231, 12'd264, 12'd299};
    logic [3:0]  exp_g;
    logic [1:0]  exp_id;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 6'(10 + i), 6'(20 + i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      exp_id = 2'((k / 3) % 4);
      exp_g  = 4'b0001 << exp_id;
      #1;
      n_tests++;
      if (k % 3 == 0) begin
        if (req_ready !== exp_g) begin
          n_fail++;
          $display("FAIL b2b_grant[%0d]: got %b want %b", k, req_ready, exp_g);
        end
      end else if (k % 3 == 1) begin
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_mul[%0d]: got rdy=%b v=%b want 0000 0", k, req_ready, rsp_valid);
        end
      end else begin
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_prod !== exp_prod[exp_id]) begin
          n_fail++;
          $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d p=%0d want 1 %0d %0d", k, rsp_valid,
                   rsp_id, rsp_prod, exp_id, exp_prod[exp_id]);
        end
      end
      if (k == 14) req_valid = '0;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  // Response held under backpressure; other requesters locked out.
  task automatic test_backpressure();
    do_reset();
    set_op(2, 6'd5, 6'd9);
    req_valid = 4'b0100;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_grant: got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1011;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_prod !== 12'd45 || rsp_id !== 2'd2 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b p=%0d id=%0d rdy=%b want 1 45 2 0000", k,
                 rsp_valid, rsp_prod, rsp_id, req_ready);
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got busy=%b v=%b want 0 0", busy, rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  // Every operand pair through requester 3.
  task automatic test_exhaustive();
    logic [11:0] exp_p;
    do_reset();
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        exp_p = 12'(a * b);
        set_op(3, 6'(a), 6'(b));
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_prod !== exp_p || rsp_id !== 2'd3) begin
          n_fail++;
          $display("FAIL exh a=%0d b=%0d: got v=%b p=%0d id=%0d want 1 %0d 3", a, b, rsp_valid,
                   rsp_prod, rsp_id, exp_p);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
      end
    end
`ifdef DADDA_MUL_SCHED_CHECK_EN
    n_tests++;
    if (chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_chk_err: got %b want 0", chk_err);
    end
`endif
  endtask

  // req1 withdraws when rr_ptr reaches it; req3 wins and rr_ptr wraps to 0.
  task automatic test_drop_wrap();
    do_reset();
    set_op(0, 6'd2, 6'd3);
    set_op(1, 6'd4, 6'd4);
    set_op(3, 6'd7, 6'd8);
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_first: got %b want 0001", req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_prod !== 12'd6) begin
      n_fail++;
      $display("FAIL drop_rsp0: got v=%b id=%0d p=%0d want 1 0 6", rsp_valid, rsp_id, rsp_prod);
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL drop_grant3: got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_prod !== 12'd56) begin
      n_fail++;
      $display("FAIL drop_rsp3: got v=%b id=%0d p=%0d want 1 3 56", rsp_valid, rsp_id, rsp_prod);
    end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_wrap: got %b want 0001", req_ready);
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_spurious[%0d]: got v=%b busy=%b want 0 0", k, rsp_valid, busy);
      end
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drop_wrap();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
